hd63701_phase_seq: RTL and testbench

//  Phase sequencer for the HD63701 core. Drives PHASE[5:0] and OPCODE[7:0] into the microcode ROM.

---
 rtl/hd63701_phase_seq_pkg.sv | 16 +
 rtl/hd63701_phase_seq_int_arb.sv | 31 +++
 rtl/hd63701_phase_seq.sv | 96 +++++++++
 tb/tb_hd63701_phase_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd63701_phase_seq_pkg.sv
// hd63701_phase_seq_pkg: phase codes, vector indices and sequencer state type for the HD63701 phase sequencer
package hd63701_phase_seq_pkg;
  typedef logic [2:0] vec_t;
  localparam vec_t VA_RST = 3'd7;
  localparam vec_t VA_NMI = 3'd6;
  localparam logic [5:0] PH_RST = 6'd0;
  localparam logic [5:0] PH_VECT = 6'd1;
  localparam logic [5:0] PH_VEC1 = 6'd2;
  localparam logic [5:0] PH_VEC2 = 6'd3;
  localparam logic [5:0] PH_EXEC = 6'd16;
  localparam logic [5:0] PH_INTR = 6'd32;
  localparam logic [5:0] PH_WAIT = 6'd48;
  localparam logic [5:0] PH_HALT = 6'd63;
  localparam int INTR_LAST = 7;
  typedef enum logic [2:0] {ST_RST, ST_VECT, ST_VEC1, ST_VEC2, ST_EXEC, ST_INTR, ST_WAIT, ST_HALT} st_t;
endpackage

// File: rtl/hd63701_phase_seq_int_arb.sv
// hd63701_int_arb: NMI falling-edge latch plus NMI/IRQ masking and priority
module hd63701_int_arb
  import hd63701_phase_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clken,
  input  logic commit,
  input  logic nmi_n,
  input  logic irq_req,
  input  vec_t irq_vec,
  input  logic i_flag,
  output logic take,
  output vec_t take_vec,
  output logic nmi_commit
);
  logic nmi_q;
  logic nmi_pend;
  assign take = nmi_pend | (irq_req & ~i_flag);
  assign take_vec = nmi_pend ? VA_NMI : irq_vec;
  assign nmi_commit = commit & nmi_pend;
  // Edge detect on the pin; a fresh edge during a commit re-arms the latch
  always_ff @(posedge clk)
    if (rst) begin
      nmi_q <= 1'b1;
      nmi_pend <= 1'b0;
    end else if (clken) begin
      nmi_q <= nmi_n;
      nmi_pend <= (nmi_q & ~nmi_n) | (nmi_pend & ~nmi_commit);
    end
endmodule

// File: rtl/hd63701_phase_seq.sv
// hd63701_phase_seq: HD63701 microcode phase sequencer; HD63701_SEQ_TRACE_EN enables the retired-instruction counter
module hd63701_phase_seq
  import hd63701_phase_seq_pkg::*;
#(
  parameter int EXEC_MAX = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clken,
  input  logic        mc_end,
  input  logic        mc_wai,
  input  logic [7:0]  DIN,
  input  logic        nmi_n,
  input  logic        irq_req,
  input  vec_t        irq_vec,
  input  logic        i_flag,
  output logic [5:0]  PHASE,
  output logic [7:0]  OPCODE,
  output vec_t        vec_sel,
  output logic        nmi_ack,
  output logic        halted,
  output logic [31:0] insn_cnt
);
  st_t  st;
  logic fetch;
  logic commit;
  logic take;
  logic nmi_commit;
  vec_t take_vec;
  assign fetch = (st == ST_VEC2 || st == ST_EXEC) && mc_end;
  assign commit = clken && (fetch || st == ST_WAIT);
  hd63701_int_arb u_arb (
    .clk(CLK),
    .rst(RST),
    .clken(clken),
    .commit(commit),
    .nmi_n(nmi_n),
    .irq_req(irq_req),
    .irq_vec(irq_vec),
    .i_flag(i_flag),
    .take(take),
    .take_vec(take_vec),
    .nmi_commit(nmi_commit)
  );
  // Phase FSM; the low PHASE bits double as the EXEC/INTR step index
  always_ff @(posedge CLK)
    if (RST) begin
      st <= ST_RST;
      PHASE <= PH_RST;
      OPCODE <= 8'h01;
      vec_sel <= VA_RST;
      nmi_ack <= 1'b0;
      halted <= 1'b0;
    end else if (clken) begin
      nmi_ack <= nmi_commit;
      case (st)
        ST_RST: begin st <= ST_VECT; PHASE <= PH_VECT; end
        ST_VECT: begin st <= ST_VEC1; PHASE <= PH_VEC1; end
        ST_VEC1: begin st <= ST_VEC2; PHASE <= PH_VEC2; end
        ST_VEC2, ST_EXEC:
          if (mc_end) begin
            OPCODE <= DIN;
            st <= take ? ST_INTR : ST_EXEC;
            PHASE <= take ? PH_INTR : PH_EXEC;
            if (take) vec_sel <= take_vec;
          end else if (st == ST_EXEC && mc_wai) begin
            st <= ST_WAIT;
            PHASE <= PH_WAIT;
          end else if (st == ST_EXEC && PHASE == PH_EXEC + 6'(EXEC_MAX)) begin
            st <= ST_HALT;
            PHASE <= PH_HALT;
            halted <= 1'b1;
          end else if (st == ST_EXEC) PHASE <= PHASE + 6'd1;
        ST_INTR:
          if (PHASE == PH_INTR + 6'(INTR_LAST)) begin
            st <= ST_VECT;
            PHASE <= PH_VECT;
          end else PHASE <= PHASE + 6'd1;
        ST_WAIT:
          if (take) begin
            st <= ST_VECT;
            PHASE <= PH_VECT;
            vec_sel <= take_vec;
          end
        default: ;
      endcase
    end
`ifdef HD63701_SEQ_TRACE_EN
  // Count opcode fetches that retire into EXEC; interrupt entries are excluded
  always_ff @(posedge CLK)
    if (RST) insn_cnt <= '0;
    else if (clken && fetch && !take) insn_cnt <= insn_cnt + 32'd1;
`else
  assign insn_cnt = '0;
`endif
endmodule

// File: tb/tb_hd63701_phase_seq.sv
// tb_hd63701_phase_seq: directed and randomized checks of the phase sequencer against a behavioural model
module tb_hd63701_phase_seq;
  localparam int EXEC_MAX = 9;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        clken = 1'b0;
  logic        mc_end = 1'b0;
  logic        mc_wai = 1'b0;
  logic [7:0]  DIN = 8'h00;
  logic        nmi_n = 1'b1;
  logic        irq_req = 1'b0;
  logic [2:0]  irq_vec = 3'd0;
  logic        i_flag = 1'b0;
  logic [5:0]  PHASE;
  logic [7:0]  OPCODE;
  logic [2:0]  vec_sel;
  logic        nmi_ack;
  logic        halted;
  logic [31:0] insn_cnt;
  int checks = 0;
  int errors = 0;
  int m_ph;
  logic [7:0] m_op;
  logic [2:0] m_vec;
  logic m_ack, m_halt, m_pend, m_prev;
  logic [31:0] m_cnt;
  logic [31:0] trace_cnt;
  logic [50:0] obs, exp_v;

  hd63701_phase_seq #(.EXEC_MAX(EXEC_MAX)) dut (
    .CLK(CLK), .RST(RST), .clken(clken), .mc_end(mc_end), .mc_wai(mc_wai), .DIN(DIN),
    .nmi_n(nmi_n), .irq_req(irq_req), .irq_vec(irq_vec), .i_flag(i_flag),
    .PHASE(PHASE), .OPCODE(OPCODE), .vec_sel(vec_sel), .nmi_ack(nmi_ack),
    .halted(halted), .insn_cnt(insn_cnt)
  );

  always #5 CLK = ~CLK;

`ifdef HD63701_SEQ_TRACE_EN
  assign trace_cnt = m_cnt;
`else
  assign trace_cnt = 32'd0;
`endif
  assign obs = {PHASE, OPCODE, vec_sel, nmi_ack, halted, insn_cnt};
  assign exp_v = {6'(m_ph), m_op, m_vec, m_ack, m_halt, trace_cnt};

  task automatic model_update();
    bit pending, boundary, commit, fall, in_exec;
    logic [2:0] vec_now;
    if (RST) begin
      m_ph = 0; m_op = 8'h01; m_vec = 3'd7; m_ack = 0; m_halt = 0; m_cnt = 0; m_pend = 0; m_prev = 1;
      return;
    end
    if (!clken) return;
    in_exec = m_ph >= 16 && m_ph <= 16 + EXEC_MAX;
    pending = m_pend || (irq_req && !i_flag);
    boundary = ((m_ph == 3 || in_exec) && mc_end) || m_ph == 48;
    commit = boundary && pending;
    vec_now = m_pend ? 3'd6 : irq_vec;
    m_ack = commit && m_pend;
    fall = m_prev && !nmi_n;
    m_prev = nmi_n;
    m_pend = fall || (m_pend && !m_ack);
    if (m_ph < 3) m_ph++;
    else if (m_ph == 3 || in_exec) begin
      if (mc_end) begin
        m_op = DIN;
        if (pending) begin m_ph = 32; m_vec = vec_now; end
        else begin m_ph = 16; m_cnt++; end
      end else if (m_ph != 3) begin
        if (mc_wai) m_ph = 48;
        else if (m_ph == 16 + EXEC_MAX) m_ph = 63;
        else m_ph++;
      end
    end else if (m_ph >= 32 && m_ph < 39) m_ph++;
    else if (m_ph == 39) m_ph = 1;
    else if (m_ph == 48 && pending) begin m_ph = 1; m_vec = vec_now; end
    m_halt = m_ph == 63;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic goto_exec(input logic [7:0] d);
    RST = 1; clken = 1; mc_end = 0; mc_wai = 0; irq_req = 0; i_flag = 0; nmi_n = 1;
    tick();
    RST = 0;
    repeat (3) tick();
    mc_end = 1; DIN = d;
    tick();
    mc_end = 0;
  endtask

  task automatic test_reset();
    clken = 0; RST = 1;
    tick();
    checks++;
    if (obs !== {6'd0, 8'h01, 3'd7, 1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL reset_values got %h want %h", obs, {6'd0, 8'h01, 3'd7, 1'b0, 1'b0, 32'd0});
    end
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_model got %h want %h", obs, exp_v); end
  endtask

  task automatic test_boot();
    int ph_seq[5] = '{1, 2, 3, 3, 3};
    RST = 0; clken = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (PHASE !== 6'(ph_seq[i]) || obs !== exp_v) begin
        errors++; $display("FAIL boot_%0d got %h want phase %0d model %h", i, obs, ph_seq[i], exp_v);
      end
    end
    mc_end = 1; DIN = 8'h86;
    tick();
    mc_end = 0;
    checks++;
    if (PHASE !== 6'd16 || OPCODE !== 8'h86 || obs !== exp_v) begin
      errors++; $display("FAIL boot_fetch got phase %0d op %h want 16 86", PHASE, OPCODE);
    end
  endtask

  task automatic test_exec_chain();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (PHASE !== 6'(i < 9 ? 17 + i : 63) || obs !== exp_v) begin
        errors++; $display("FAIL exec_chain_%0d got %h model %h", i, obs, exp_v);
      end
    end
    mc_end = 1;
    repeat (2) tick();
    mc_end = 0;
    checks++;
    if (PHASE !== 6'd63 || halted !== 1'b1 || obs !== exp_v) begin
      errors++; $display("FAIL halt_sticky got phase %0d halted %b want 63 1", PHASE, halted);
    end
  endtask

  task automatic test_irq();
    goto_exec(8'h20);
    repeat (2) tick();
    irq_req = 1; i_flag = 0; irq_vec = 3'd3; mc_end = 1; DIN = 8'h3a;
    tick();
    mc_end = 0;
    checks++;
    if (PHASE !== 6'd32 || vec_sel !== 3'd3 || obs !== exp_v) begin
      errors++; $display("FAIL irq_entry got phase %0d vec %0d want 32 3", PHASE, vec_sel);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (PHASE !== 6'(i < 7 ? 33 + i : 1) || obs !== exp_v) begin
        errors++; $display("FAIL irq_seq_%0d got %h model %h", i, obs, exp_v);
      end
    end
    repeat (2) tick();
    i_flag = 1; mc_end = 1; DIN = 8'h4c;
    tick();
    mc_end = 0;
    checks++;
    if (PHASE !== 6'd16 || OPCODE !== 8'h4c || obs !== exp_v) begin
      errors++; $display("FAIL irq_masked got phase %0d op %h want 16 4c", PHASE, OPCODE);
    end
    irq_req = 0; i_flag = 0;
  endtask

  task automatic test_nmi();
    goto_exec(8'h01);
    irq_req = 1; i_flag = 0; irq_vec = 3'd2; nmi_n = 0;
    tick();
    mc_end = 1; DIN = 8'h55;
    tick();
    mc_end = 0; nmi_n = 1;
    checks++;
    if (PHASE !== 6'd32 || vec_sel !== 3'd6 || nmi_ack !== 1'b1 || obs !== exp_v) begin
      errors++; $display("FAIL nmi_entry got phase %0d vec %0d ack %b want 32 6 1", PHASE, vec_sel, nmi_ack);
    end
    tick();
    checks++;
    if (nmi_ack !== 1'b0 || obs !== exp_v) begin
      errors++; $display("FAIL nmi_ack_pulse got %b want 0", nmi_ack);
    end
    repeat (2) tick();
    checks++;
    if (PHASE !== 6'd35) begin errors++; $display("FAIL nmi_intr3 got %0d want 35", PHASE); end
    nmi_n = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL nmi_seq_%0d got %h model %h", i, obs, exp_v); end
    end
    irq_req = 0; mc_end = 1;
    tick();
    mc_end = 0; nmi_n = 1;
    checks++;
    if (PHASE !== 6'd32 || vec_sel !== 3'd6 || nmi_ack !== 1'b1 || obs !== exp_v) begin
      errors++; $display("FAIL nmi_second got phase %0d vec %0d ack %b want 32 6 1", PHASE, vec_sel, nmi_ack);
    end
  endtask

  task automatic test_wai();
    goto_exec(8'h3e);
    repeat (5) tick();
    mc_wai = 1;
    tick();
    checks++;
    if (PHASE !== 6'd48 || obs !== exp_v) begin errors++; $display("FAIL wai_enter got %0d want 48", PHASE); end
    repeat (3) tick();
    checks++;
    if (PHASE !== 6'd48 || obs !== exp_v) begin errors++; $display("FAIL wai_hold got %0d want 48", PHASE); end
    mc_wai = 0; irq_req = 1; i_flag = 0; irq_vec = 3'd2;
    tick();
    irq_req = 0;
    checks++;
    if (PHASE !== 6'd1 || vec_sel !== 3'd2 || obs !== exp_v) begin
      errors++; $display("FAIL wai_wake got phase %0d vec %0d want 1 2", PHASE, vec_sel);
    end
    goto_exec(8'h10);
    mc_end = 1; mc_wai = 1; DIN = 8'h77;
    tick();
    mc_end = 0; mc_wai = 0;
    checks++;
    if (PHASE !== 6'd16 || OPCODE !== 8'h77 || obs !== exp_v) begin
      errors++; $display("FAIL end_beats_wai got phase %0d want 16", PHASE);
    end
  endtask

  task automatic test_clken();
    RST = 1; clken = 1;
    tick();
    RST = 0;
    for (int i = 0; i < 12; i++) begin
      clken = (i % 3 == 0);
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL clken_%0d got %h model %h", i, obs, exp_v); end
    end
    checks++;
    if (PHASE !== 6'd3) begin errors++; $display("FAIL clken_phase got %0d want 3", PHASE); end
    clken = 1; mc_end = 1;
    for (int i = 0; i < 5; i++) begin
      DIN = 8'($urandom);
      tick();
    end
    mc_end = 0;
    checks++;
`ifdef HD63701_SEQ_TRACE_EN
    if (insn_cnt !== 32'd5 || obs !== exp_v) begin errors++; $display("FAIL trace_cnt got %0d want 5", insn_cnt); end
`else
    if (insn_cnt !== 32'd0 || obs !== exp_v) begin errors++; $display("FAIL trace_cnt got %0d want 0", insn_cnt); end
`endif
    RST = 1; clken = 0;
    tick();
    RST = 0;
    checks++;
    if (PHASE !== 6'd0 || obs !== exp_v) begin errors++; $display("FAIL reset_over_clken got %0d want 0", PHASE); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 79) == 0);
      clken = ($urandom_range(0, 3) != 0);
      mc_end = ($urandom_range(0, 2) == 0);
      mc_wai = ($urandom_range(0, 14) == 0);
      DIN = 8'($urandom);
      if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
      irq_req = ($urandom_range(0, 5) == 0);
      irq_vec = 3'($urandom_range(0, 5));
      i_flag = 1'($urandom);
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_%0d got %h model %h", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_exec_chain();
    test_irq();
    test_nmi();
    test_wai();
    test_clken();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
